varint_decode_0: RTL
====================

# varint_decode_0

Downstream consumer of the varint input FIFO and index FIFO filled by `fsm_0` from the AXI write slave. It pops one message-length entry from the index FIFO, then pops the message's 32-bit words from the varint FIFO. It decodes the byte stream as protobuf LEB128 varints and emits each decoded 64-bit value on a valid/ready stream with end-of-message and error flags.

## Interface
- `MAX_BYTES`, default 10: maximum varint length in bytes; the byte at position `MAX_BYTES-1` is the last legal byte.
- `clk`  in  1  sole clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-low reset (0 = reset), sampled on `clk` rising edge.
- `varint_in_fifo_empty`  in  1  varint word FIFO empty.
- `varint_in_fifo_rdata`  in  32  show-ahead head word; byte 0 = bits [7:0], stream order LSB byte first.
- `varint_in_fifo_pop`  out  1  consume head word this edge.
- `varint_in_index_empty`  in  1  index FIFO empty.
- `varint_in_index_rdata`  in  10  show-ahead head entry: message length in bytes (0..1023).
- `varint_in_index_pop`  out  1  consume head entry this edge.
- `varint_out_valid`  out  1  decoded value available.
- `varint_out_ready`  in  1  consumer accepts value.
- `varint_out_data`  out  64  decoded value.
- `varint_out_last`  out  1  value is the final one of its message.
- `varint_out_err`  out  1  value is malformed (overlong, overflow, or truncated).
- `busy`  out  1  state is not IDLE.

## Operation
- States: IDLE, FETCH, DECODE.
- IDLE: if `!varint_in_index_empty`, assert `varint_in_index_pop` for one cycle and latch `len = rdata`, `rem = rdata`.
  - If `len == 0`: stay in IDLE; no words consumed, no output.
  - Otherwise: go to FETCH.
- FETCH: if `!varint_in_fifo_empty`, latch the word into the byte shift register, assert `varint_in_fifo_pop`, set `bpos = 0`, go to DECODE. Otherwise wait.
- DECODE: processes one byte per cycle, `b = word[8*bpos +: 8]`; decrements `rem`.
  - Accumulate: `acc |= b[6:0] << 7*k`, with `k` = byte count within the current varint (0..MAX_BYTES-1).
  - Stall: no byte is processed while `varint_out_valid && !varint_out_ready`.
  - `b[7] == 0`: terminates the varint. Load the output register with `acc`, set `last = (rem == 1)`, then clear `acc` and `k`.
  - `k == MAX_BYTES-1` and (`b[7] == 1` or `b[6:1] != 0`): overflow/overlong.
    - Emit `acc` with `err = 1`.
    - Enter discard mode: drop bytes until one with `b[7] == 0`, inclusive. Discarded bytes produce no output.
    - Resume normal decoding afterwards.
  - `rem` reaches 0 with `b[7] == 1` (truncated): emit `acc` with `err = 1`, `last = 1`.
  - Truncation in discard mode: no new output is produced, but `last` must still reach the consumer. If the overflow value is still pending, set its `last`; otherwise emit `acc = 0` with `err = 1`, `last = 1`.
  - After `bpos == 3` or `rem` reaches 0: go to FETCH if `rem != 0`, else IDLE. Unused upper bytes of the final word are ignored.
- Every message of length ≥1 produces exactly one output with `last = 1`.
- Output register semantics: `varint_out_valid` sets when a value is loaded and clears on handshake, unless a new value is loaded in the same cycle.

## Timing
- Reset values: all outputs 0; state IDLE; `acc`, `k`, `rem`, discard flag cleared.
- Pops are single-cycle pulses, asserted only when the respective `empty` is 0. There is never more than one word pop per FETCH cycle.
- Latency, both FIFOs non-empty: IDLE pop at cycle 0, word pop at cycle 1, first byte decoded at cycle 2, `varint_out_valid` high at cycle 3.
- Throughput: 1 byte/clk inside a word, plus one FETCH bubble per word.
- Output hold: `varint_out_data`, `varint_out_last` and `varint_out_err` stay stable while `valid && !ready`.
- Reset mid-message: returns to IDLE within the reset cycle and drops `varint_out_valid`. The partial message is discarded; the upstream `*_clr` pulses from `fsm_0` flush the FIFOs.
- Upstream empty mid-message: the block waits in FETCH indefinitely with no pops and no output.

## Test plan
- Index 1, word 0x00000005 -> one pop of each FIFO; output `data = 5`, `last = 1`, `err = 0`, valid at cycle 3.
- Index 3, word 0x00_01_AC_02 (bytes 02, AC, 01) -> outputs 2 (last 0), then 0x2C+(1<<7) = 172 (last 1).
- Index 10, bytes FF×9 then 01 across 3 words -> `data = 0xFFFFFFFFFFFFFFFF`, `err = 0`, `last = 1`, 3 word pops.
- Index 11, bytes 80×10 then 00 -> one output with `err = 1`, `last = 1`; the 11th byte is consumed in discard mode with no extra output.
- Index 2, bytes 81, 81 -> `data = 0x81`, `err = 1`, `last = 1`. Follow with index 0 -> index popped, no word pop, no output.
- Hold `varint_out_ready = 0` for 5 cycles with 4 single-byte varints queued -> values stable and no bytes lost; drive `reset = 0` mid-message -> all outputs 0 the next cycle.

Source files
------------

// File: rtl/varint_decode_0_if.sv
// FIFO-side and stream-side signals of the varint decoder.
// slave is the decoder's view; master is the surrounding logic's view.
interface varint_decode_0_if;
    logic        varint_in_fifo_empty;
    logic [31:0] varint_in_fifo_rdata;
    logic        varint_in_fifo_pop;
    logic        varint_in_index_empty;
    logic [9:0]  varint_in_index_rdata;
    logic        varint_in_index_pop;
    logic        varint_out_valid;
    logic        varint_out_ready;
    logic [63:0] varint_out_data;
    logic        varint_out_last;
    logic        varint_out_err;

    modport master (
        output varint_in_fifo_empty, varint_in_fifo_rdata,
        output varint_in_index_empty, varint_in_index_rdata,
        output varint_out_ready,
        input  varint_in_fifo_pop, varint_in_index_pop,
        input  varint_out_valid, varint_out_data, varint_out_last, varint_out_err
    );

    modport slave (
        input  varint_in_fifo_empty, varint_in_fifo_rdata,
        input  varint_in_index_empty, varint_in_index_rdata,
        input  varint_out_ready,
        output varint_in_fifo_pop, varint_in_index_pop,
        output varint_out_valid, varint_out_data, varint_out_last, varint_out_err
    );
endinterface

// File: rtl/varint_decode_0.sv
// Pops a message length, then that many bytes of 32-bit words, and decodes them as
// LEB128 varints onto a valid/ready stream with last/err flags.
module varint_decode_0 #(
    parameter int MAX_BYTES = 10
) (
    input  logic               clk,
    input  logic               reset,
    varint_decode_0_if.slave   bus,
    output logic               busy
);

    localparam int KW = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] FETCH  = 2'd1;
    localparam logic [1:0] DECODE = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [31:0]   word_q, word_d;
    logic [1:0]    bpos_q, bpos_d;
    logic [9:0]    rem_q, rem_d;
    logic [63:0]   acc_q, acc_d;
    logic [KW-1:0] k_q, k_d;
    logic          disc_q, disc_d;
    logic          vld_q, vld_d;
    logic [63:0]   data_q, data_d;
    logic          last_q, last_d;
    logic          err_q, err_d;

    logic          index_pop, fifo_pop;
    logic          stall, last_byte, at_max, ovf, load;
    logic [7:0]    byte_v;
    logic [63:0]   acc_new, ld_data;
    logic          ld_last, ld_err;

    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        state_d   = state_q;
        word_d    = word_q;
        bpos_d    = bpos_q;
        rem_d     = rem_q;
        acc_d     = acc_q;
        k_d       = k_q;
        disc_d    = disc_q;
        vld_d     = vld_q;
        data_d    = data_q;
        last_d    = last_q;
        err_d     = err_q;
        index_pop = 1'b0;
        fifo_pop  = 1'b0;
        load      = 1'b0;
        ld_data   = '0;
        ld_last   = 1'b0;
        ld_err    = 1'b0;

        stall     = vld_q && !bus.varint_out_ready;
        byte_v    = word_q[{bpos_q, 3'b000} +: 8];
        last_byte = (rem_q == 10'd1);
        acc_new   = acc_q | (64'(byte_v[6:0]) << (7 * k_q));
        at_max    = (k_q == KW'(MAX_BYTES - 1));
        ovf       = at_max && (byte_v[7] || (byte_v[6:1] != 6'd0));

        if (vld_q && bus.varint_out_ready) begin
            vld_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (!bus.varint_in_index_empty) begin
                    index_pop = 1'b1;
                    rem_d     = bus.varint_in_index_rdata;
                    state_d   = (bus.varint_in_index_rdata == 10'd0) ? IDLE : FETCH;
                end
            end
            FETCH: begin
                if (!bus.varint_in_fifo_empty) begin
                    fifo_pop = 1'b1;
                    word_d   = bus.varint_in_fifo_rdata;
                    bpos_d   = 2'd0;
                    state_d  = DECODE;
                end
            end
            DECODE: begin
                if (!stall) begin
                    rem_d = rem_q - 10'd1;
                    // An overflowed value is parked in acc until its discard run ends,
                    // so it leaves with the correct last flag as a single output.
                    if (disc_q) begin
                        if (!byte_v[7] || last_byte) begin
                            load    = 1'b1;
                            ld_data = acc_q;
                            ld_err  = 1'b1;
                            ld_last = last_byte;
                            acc_d   = '0;
                            k_d     = '0;
                            disc_d  = 1'b0;
                        end
                    end else if (ovf && byte_v[7] && !last_byte) begin
                        acc_d  = acc_new;
                        disc_d = 1'b1;
                    end else if (!byte_v[7] || last_byte || ovf) begin
                        load    = 1'b1;
                        ld_data = acc_new;
                        ld_err  = ovf || byte_v[7];
                        ld_last = last_byte;
                        acc_d   = '0;
                        k_d     = '0;
                    end else begin
                        acc_d = acc_new;
                        k_d   = k_q + KW'(1);
                    end

                    if ((bpos_q == 2'd3) || last_byte) begin
                        state_d = last_byte ? IDLE : FETCH;
                    end else begin
                        bpos_d = bpos_q + 2'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            vld_d  = 1'b1;
            data_d = ld_data;
            last_d = ld_last;
            err_d  = ld_err;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            bpos_q  <= 2'd0;
            rem_q   <= '0;
            acc_q   <= '0;
            k_q     <= '0;
            disc_q  <= 1'b0;
            vld_q   <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bpos_q  <= bpos_d;
            rem_q   <= rem_d;
            acc_q   <= acc_d;
            k_q     <= k_d;
            disc_q  <= disc_d;
            vld_q   <= vld_d;
            data_q  <= data_d;
            last_q  <= last_d;
            err_q   <= err_d;
        end
    end

    // NOTE: the word buffer is pure datapath, always reloaded in FETCH before use, so it has no reset.
    always_ff @(posedge clk) begin
        word_q <= word_d;
    end

    assign bus.varint_in_index_pop = reset && index_pop;
    assign bus.varint_in_fifo_pop  = reset && fifo_pop;
    assign bus.varint_out_valid    = vld_q;
    assign bus.varint_out_data     = data_q;
    assign bus.varint_out_last     = last_q;
    assign bus.varint_out_err      = err_q;
    assign busy                    = (state_q != IDLE);

endmodule
